sync_ram_clr: RTL

//   Parametrised single-port synchronous RAM; successor to the fixed 16x4 SyncRAM.

---
 rtl/sync_ram_clr_if.sv | 29 ++
 rtl/sync_ram_clr.sv | 133 +++++++++++++
 2 files changed

// File: rtl/sync_ram_clr_if.sv
// Bus interface for sync_ram_clr.
// Groups the access, clear and status signals of the RAM.
//   master : drives we, re, address, data_in, wmask and clear;
//            observes data_out, rvalid and busy
//   slave  : the RAM side of the same signals
interface sync_ram_clr_if #(
  parameter int DATA_WIDTH = 4,
  parameter int ADDR_WIDTH = 4
);
  logic                  we;
  logic                  re;
  logic [ADDR_WIDTH-1:0] address;
  logic [DATA_WIDTH-1:0] data_in;
  logic [DATA_WIDTH-1:0] wmask;
  logic                  clear;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  rvalid;
  logic                  busy;

  modport master (
    output we, re, address, data_in, wmask, clear,
    input  data_out, rvalid, busy
  );

  modport slave (
    input  we, re, address, data_in, wmask, clear,
    output data_out, rvalid, busy
  );
endinterface

// File: rtl/sync_ram_clr.sv
// Parametrised single-port synchronous RAM with a hardware clear sequencer.
// Ports:
//   clk   : single clock, all logic on the rising edge
//   reset : synchronous active-high; restarts the clear sweep from address 0
//   bus   : slave side of sync_ram_clr_if
//           we/re/address/data_in/wmask : masked write and 1-cycle-latency read
//           clear    : one-cycle request to sweep memory to CLEAR_VALUE
//           data_out : registered read data, holds the last read value
//           rvalid   : one-cycle pulse when data_out was updated
//           busy     : high while the clear sweep runs (accesses are ignored)
module sync_ram_clr #(
  parameter int                    DATA_WIDTH  = 4,
  parameter int                    ADDR_WIDTH  = 4,
  parameter int                    RDW_MODE    = 0,
  parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE = '0
) (
  input logic           clk,
  input logic           reset,
  sync_ram_clr_if.slave bus
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

  // Bitwise merge of new data into an old word under a write mask.
  function automatic logic [DATA_WIDTH-1:0] merge_word(
    input logic [DATA_WIDTH-1:0] old_word,
    input logic [DATA_WIDTH-1:0] new_word,
    input logic [DATA_WIDTH-1:0] mask
  );
    return (old_word & ~mask) | (new_word & mask);
  endfunction

  logic [DATA_WIDTH-1:0] mem_r [DEPTH];

  state_t                state_r;
  state_t                state_nxt_s;
  logic [ADDR_WIDTH-1:0] clr_addr_r;
  logic [ADDR_WIDTH-1:0] clr_addr_nxt_s;
  logic [DATA_WIDTH-1:0] data_out_r;
  logic                  rvalid_r;

  logic [DATA_WIDTH-1:0] old_word_s;
  logic [DATA_WIDTH-1:0] merged_word_s;
  logic                  mem_we_s;
  logic [ADDR_WIDTH-1:0] mem_waddr_s;
  logic [DATA_WIDTH-1:0] mem_wdata_s;
  logic                  rd_en_s;
  logic [DATA_WIDTH-1:0] rd_word_s;

  assign old_word_s    = mem_r[bus.address];
  assign merged_word_s = merge_word(old_word_s, bus.data_in, bus.wmask);

  // Next-state logic plus memory write port selection (sweep vs. user write).
  always_comb begin
    state_nxt_s    = state_r;
    clr_addr_nxt_s = clr_addr_r;
    mem_we_s       = 1'b0;
    mem_waddr_s    = bus.address;
    mem_wdata_s    = merged_word_s;
    rd_en_s        = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (bus.clear) begin
          // clear wins: any access requested in the same cycle is dropped
          state_nxt_s    = ST_CLEAR;
          clr_addr_nxt_s = '0;
        end else begin
          mem_we_s = bus.we;
          rd_en_s  = bus.re;
        end
      end
      ST_CLEAR: begin
        mem_we_s       = 1'b1;
        mem_waddr_s    = clr_addr_r;
        mem_wdata_s    = CLEAR_VALUE;
        clr_addr_nxt_s = clr_addr_r + ADDR_WIDTH'(1);
        if (&clr_addr_r) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_CLEAR;
        end
      end
      default: begin
        state_nxt_s    = ST_CLEAR;
        clr_addr_nxt_s = '0;
      end
    endcase
  end

  // Read-during-write selection: old word, or the merged word being written.
  always_comb begin
    rd_word_s = old_word_s;
    if ((RDW_MODE != 0) && bus.we) begin
      rd_word_s = merged_word_s;
    end else begin
      rd_word_s = old_word_s;
    end
  end

  // Memory array write port; the reset edge itself never writes.
  always_ff @(posedge clk) begin
    if (!reset && mem_we_s) begin
      mem_r[mem_waddr_s] <= mem_wdata_s;
    end
  end

  // Control state, sweep pointer and registered read outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= ST_CLEAR;
      clr_addr_r <= '0;
      data_out_r <= '0;
      rvalid_r   <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      clr_addr_r <= clr_addr_nxt_s;
      rvalid_r   <= rd_en_s;
      if (rd_en_s) begin
        data_out_r <= rd_word_s;
      end
    end
  end

  assign bus.data_out = data_out_r;
  assign bus.rvalid   = rvalid_r;
  assign bus.busy     = (state_r == ST_CLEAR);

endmodule
